// File: rtl/alu_pkg.sv
// Shared constants and types for the rotate datapath and its arbiter.
package alu_pkg;

    localparam int unsigned ROT_W     = 16;
    localparam int unsigned ROT_AMT_W = 4;

    // Rotate direction encoding
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    // Requester IDs reported with each result
    localparam logic SRC_UART = 1'b0;
    localparam logic SRC_ALU  = 1'b1;

    // One-entry result buffer occupancy
    typedef enum logic {
        StEmpty,
        StFull
    } buf_state_e;

endpackage

// File: rtl/rotate_operation.sv
// Combinational 16-bit rotate, left or right by 0-15 positions.
module rotate_operation
    import alu_pkg::*;
(
    input  logic [ROT_W-1:0]     data_i,
    input  logic [ROT_AMT_W-1:0] amt_i,
    input  logic                 left_i,
    output logic [ROT_W-1:0]     result_o
);

    logic [2*ROT_W-1:0] doubled;
    logic [2*ROT_W-1:0] shifted;

    // Rotate by shifting a doubled copy; the wrapped bits fall into the kept half.
    always_comb begin
        doubled = {data_i, data_i};
        shifted = '0;
        if (left_i == DIR_LEFT) begin
            shifted  = doubled << amt_i;
            result_o = shifted[2*ROT_W-1:ROT_W];
        end else begin
            shifted  = doubled >> amt_i;
            result_o = shifted[ROT_W-1:0];
        end
    end

endmodule

// File: rtl/rotate_arbiter.sv
// Two-port arbiter sharing one rotate unit, with a one-entry result buffer.
module rotate_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N     = ROT_W,
    parameter int unsigned RR_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [N-1:0]         req0_data,
    input  logic [ROT_AMT_W-1:0] req0_amt,
    input  logic                 req0_left,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [N-1:0]         req1_data,
    input  logic [ROT_AMT_W-1:0] req1_amt,
    input  logic                 req1_left,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_data,
    output logic                 res_src,
    output logic                 busy
);

    buf_state_e state_q, state_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic         res_src_q, res_src_d;
    logic         last_grant_q, last_grant_d;

    logic                 grant;
    logic                 can_accept;
    logic                 accept;
    logic [N-1:0]         rot_data;
    logic [ROT_AMT_W-1:0] rot_amt;
    logic                 rot_left;
    logic [N-1:0]         rot_result;

    // Pick a port: lone requester wins; on contention RR or fixed priority to port 0.
    always_comb begin
        grant = SRC_UART;
        if (req0_valid && req1_valid) begin
            grant = (RR_EN != 0) ? ~last_grant_q : SRC_UART;
        end else if (req1_valid) begin
            grant = SRC_ALU;
        end
    end

    // Handshake: accept when empty, or when full and the consumer drains this cycle.
    always_comb begin
        can_accept = (state_q == StEmpty) || res_ready;
        req0_ready = (grant == SRC_UART) && can_accept && !rst;
        req1_ready = (grant == SRC_ALU) && can_accept && !rst;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // Steer the granted payload into the shared rotator.
    always_comb begin
        rot_data = req0_data;
        rot_amt  = req0_amt;
        rot_left = req0_left;
        if (grant == SRC_ALU) begin
            rot_data = req1_data;
            rot_amt  = req1_amt;
            rot_left = req1_left;
        end
    end

    rotate_operation u_rotate (
        .data_i   (rot_data),
        .amt_i    (rot_amt),
        .left_i   (rot_left),
        .result_o (rot_result)
    );

    // Buffer next state: load on accept, empty on drain without refill, else hold.
    always_comb begin
        state_d      = state_q;
        res_data_d   = res_data_q;
        res_src_d    = res_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            state_d      = StFull;
            res_data_d   = rot_result;
            res_src_d    = grant;
            last_grant_d = grant;
        end else if (state_q == StFull && res_ready) begin
            state_d = StEmpty;
        end
    end

    // State registers; last_grant resets to port 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            res_data_q   <= '0;
            res_src_q    <= SRC_UART;
            last_grant_q <= SRC_ALU;
        end else begin
            state_q      <= state_d;
            res_data_q   <= res_data_d;
            res_src_q    <= res_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs come straight from the buffer registers.
    always_comb begin
        res_valid = (state_q == StFull);
        res_data  = res_data_q;
        res_src   = res_src_q;
        busy      = res_valid || req0_valid || req1_valid;
    end

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench for rotate_arbiter with a result scoreboard.
module tb_rotate_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, r0, l0, v1, r1, l1;
    logic [15:0] d0, d1;
    logic [3:0]  a0, a1;
    logic        res_valid, rr, res_src, busy;
    logic [15:0] res_data;

    // Fixed-priority instance
    logic        fv0, fr0, fv1, fr1, f_res_valid, f_res_src, f_busy;
    logic [15:0] f_res_data;

    int passed = 0;
    int total  = 0;
    logic [16:0] sb_q[$];
    logic        grants[$];

    always #5 clk = ~clk;

    rotate_arbiter #(.N(16), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(r0), .req0_data(d0), .req0_amt(a0), .req0_left(l0),
        .req1_valid(v1), .req1_ready(r1), .req1_data(d1), .req1_amt(a1), .req1_left(l1),
        .res_valid(res_valid), .res_ready(rr), .res_data(res_data), .res_src(res_src),
        .busy(busy)
    );

    rotate_arbiter #(.N(16), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(fv0), .req0_ready(fr0), .req0_data(16'h1111), .req0_amt(4'd1),
        .req0_left(1'b1),
        .req1_valid(fv1), .req1_ready(fr1), .req1_data(16'h2222), .req1_amt(4'd1),
        .req1_left(1'b0),
        .res_valid(f_res_valid), .res_ready(1'b1), .res_data(f_res_data),
        .res_src(f_res_src), .busy(f_busy)
    );

    // Bit-at-a-time reference rotate
    function automatic logic [15:0] model_rot(logic [15:0] d, logic [3:0] amt, logic left);
        logic [15:0] r = d;
        for (int i = 0; i < int'(amt); i++) begin
            r = left ? {r[14:0], r[15]} : {r[0], r[15:1]};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // One clock: scoreboard sampled at negedge, inputs may change at posedge+1 afterwards.
    task automatic tick();
        logic [16:0] e;
        @(negedge clk);
        if (!rst) begin
            if (res_valid && rr) begin
                check("sb_has_entry", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_data", {16'd0, res_data}, {16'd0, e[15:0]});
                    check("sb_src", {31'd0, res_src}, {31'd0, e[16]});
                end
            end
            if (v0 && r0) begin
                sb_q.push_back({1'b0, model_rot(d0, a0, l0)});
                grants.push_back(1'b0);
            end
            if (v1 && r1) begin
                sb_q.push_back({1'b1, model_rot(d1, a1, l1)});
                grants.push_back(1'b1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rr = 1'b0;
        v0 = 1'b1; d0 = '0; a0 = '0; l0 = 1'b0;
        v1 = 1'b1; d1 = '0; a1 = '0; l1 = 1'b0;
        fv0 = 1'b0; fv1 = 1'b0;
        @(posedge clk); #1;
        tick();
        // Reset state
        check("rst_ready0", {31'd0, r0}, 32'd0);
        check("rst_ready1", {31'd0, r1}, 32'd0);
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", {16'd0, res_data}, 32'd0);
        check("rst_src", {31'd0, res_src}, 32'd0);
        v0 = 1'b0; v1 = 1'b0; rst = 1'b0; rr = 1'b1;
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single request on port 0
        v0 = 1'b1; d0 = 16'h0008; a0 = 4'd1; l0 = 1'b1;
        #1;
        check("single_ready0", {31'd0, r0}, 32'd1);
        check("single_busy", {31'd0, busy}, 32'd1);
        tick();
        v0 = 1'b0;
        check("single_valid", {31'd0, res_valid}, 32'd1);
        check("single_data", {16'd0, res_data}, 32'h0010);
        check("single_src", {31'd0, res_src}, 32'd0);
        tick();
        check("single_drained", {31'd0, res_valid}, 32'd0);

        // Wrap cases on port 1
        v1 = 1'b1; d1 = 16'h8001; a1 = 4'd1; l1 = 1'b1;
        tick();
        d1 = 16'h1234; a1 = 4'd4; l1 = 1'b0;
        check("wrap_left", {16'd0, res_data}, 32'h0003);
        check("wrap_left_src", {31'd0, res_src}, 32'd1);
        tick();
        v1 = 1'b0;
        check("wrap_right", {16'd0, res_data}, 32'h4123);
        check("wrap_right_src", {31'd0, res_src}, 32'd1);
        tick();

        // Round-robin contention, no bubbles
        grants.delete();
        v0 = 1'b1; d0 = 16'h0001; a0 = 4'd3; l0 = 1'b1;
        v1 = 1'b1; d1 = 16'hF000; a1 = 4'd2; l1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_no_bubble", {31'd0, res_valid}, 32'd1);
        end
        v0 = 1'b0; v1 = 1'b0;
        check("rr_count", grants.size(), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            check("rr_order", {31'd0, grants[i]}, i % 2);
        end
        tick();

        // Backpressure: buffer holds 0x00F0 while port 0 waits
        rr = 1'b0;
        v0 = 1'b1; d0 = 16'h000F; a0 = 4'd4; l0 = 1'b1;
        tick();
        d0 = 16'h0F00;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready0", {31'd0, r0}, 32'd0);
            tick();
            check("bp_hold_data", {16'd0, res_data}, 32'h00F0);
            check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
        end
        rr = 1'b1;
        #1;
        check("bp_release_ready0", {31'd0, r0}, 32'd1);
        tick();
        v0 = 1'b0;
        check("bp_next_data", {16'd0, res_data}, 32'hF000);
        tick();

        // amt=0 in both directions
        v0 = 1'b1; d0 = 16'hA5A5; a0 = 4'd0; l0 = 1'b1;
        tick();
        v0 = 1'b0;
        check("amt0_left", {16'd0, res_data}, 32'hA5A5);
        v1 = 1'b1; d1 = 16'hA5A5; a1 = 4'd0; l1 = 1'b0;
        tick();
        v1 = 1'b0;
        check("amt0_right", {16'd0, res_data}, 32'hA5A5);
        tick();

        // Fixed priority instance: port 0 always wins
        fv0 = 1'b1; fv1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fp_ready0", {31'd0, fr0}, 32'd1);
            check("fp_ready1", {31'd0, fr1}, 32'd0);
            tick();
            check("fp_src", {31'd0, f_res_src}, 32'd0);
            check("fp_data", {16'd0, f_res_data}, 32'h2222);
        end
        fv0 = 1'b0; fv1 = 1'b0;

        // Reset while full with both ports valid
        rr = 1'b0;
        v0 = 1'b1; d0 = 16'h0001; a0 = 4'd1; l0 = 1'b1;
        tick();
        check("prerst_full", {31'd0, res_valid}, 32'd1);
        v1 = 1'b1; d1 = 16'h0001; a1 = 4'd1; l1 = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_ready0", {31'd0, r0}, 32'd0);
        check("rst_mid_ready1", {31'd0, r1}, 32'd0);
        tick();
        sb_q.delete();
        check("rst_mid_valid", {31'd0, res_valid}, 32'd0);
        check("rst_mid_ready0_b", {31'd0, r0}, 32'd0);
        check("rst_mid_ready1_b", {31'd0, r1}, 32'd0);
        rst = 1'b0; rr = 1'b1;
        #1;
        check("postrst_ready0", {31'd0, r0}, 32'd1);
        check("postrst_ready1", {31'd0, r1}, 32'd0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        check("postrst_src", {31'd0, res_src}, 32'd0);
        check("postrst_data", {16'd0, res_data}, 32'h0002);
        tick();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
